// File: rtl/riscy_data_mem_responder_pkg.sv
// Shared types and helpers for the RI5CY data-memory responder.
package riscy_mem_pkg;

    localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;
    localparam int unsigned TIMER_W      = 4;
    localparam int unsigned QCNT_W       = 3;

    // One queued response; timer holds the cycles still to wait before rvalid.
    typedef struct packed {
        logic [31:0]        rdata;
        logic               err;
        logic [TIMER_W-1:0] timer;
    } rsp_entry_t;

    // Byte-lane merge of a store into an existing word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/riscy_data_mem_responder_if.sv
// RI5CY data-memory bus bundle; the core is the master, the responder the slave.
interface riscy_data_mem_responder_if;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/riscy_data_mem_responder_rsp_queue.sv
// In-order response FIFO; every stored entry counts down so that queued
// responses keep their own latency while leaving strictly in order.
module riscy_rsp_queue
    import riscy_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  rsp_entry_t        push_entry_i,
    input  logic              pop_i,
    output rsp_entry_t        head_o,
    output logic              head_valid_o,
    output logic [QCNT_W-1:0] count_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t        entries_q [DEPTH];
    rsp_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [QCNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_o       = entries_q[rd_ptr_q];
    assign head_valid_o = (count_q != '0);
    assign full_o       = (32'(count_q) == DEPTH);
    assign count_o      = count_q;

    // Countdown of all timers, pop at the head, push at the tail.
    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].timer != '0) begin
                entries_d[i].timer = entries_q[i].timer - TIMER_W'(1);
            end
        end
        if (pop_i && head_valid_o) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_d - QCNT_W'(1);
        end
        if (push_i && (!full_o || pop_i)) begin
            entries_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            count_d             = count_d + QCNT_W'(1);
        end
    end

    // Queue state register; reset discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/riscy_data_mem_responder.sv
// Memory-side responder for the RI5CY data interface: grant throttling,
// word-addressed SRAM with backdoor preload, ordered delayed responses and
// a store-observe port.
module riscy_data_mem_responder
    import riscy_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned GNT_DELAY   = 0,
    parameter int unsigned RSP_DELAY   = 1,
    parameter int unsigned OUTSTANDING = 2,
    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    riscy_data_mem_responder_if.slave bus,
    input  logic                      bd_we_i,
    input  logic [IDX_W-1:0]          bd_addr_i,
    input  logic [31:0]               bd_wdata_i,
    output logic                      st_valid_o,
    output logic [31:0]               st_addr_o,
    output logic [31:0]               st_data_o,
    output logic [3:0]                st_be_o
);

    logic [3:0]        gnt_cnt_q, gnt_cnt_d;
    logic              st_valid_q, st_valid_d;
    logic [31:0]       st_addr_q, st_addr_d;
    logic [31:0]       st_data_q, st_data_d;
    logic [3:0]        st_be_q, st_be_d;
    logic [31:0]       mem_q [MEM_WORDS];

    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              rsp_fire;
    logic              slot_free;
    logic              accept;
    logic              bus_wr;
    rsp_entry_t        head;
    rsp_entry_t        push_entry;
    logic              head_valid;
    logic              q_full;
    logic [QCNT_W-1:0] pend_cnt;

    riscy_rsp_queue #(
        .DEPTH (OUTSTANDING)
    ) u_rsp_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (accept),
        .push_entry_i (push_entry),
        .pop_i        (rsp_fire),
        .head_o       (head),
        .head_valid_o (head_valid),
        .count_o      (pend_cnt),
        .full_o       (q_full)
    );

    // Address decode, grant decision and the entry pushed on accept.
    always_comb begin
        offset     = bus.data_addr_i - BASE_ADDR;
        in_range   = (bus.data_addr_i >= BASE_ADDR) && ((offset >> 2) < 32'(MEM_WORDS));
        idx        = offset[2 +: IDX_W];
        rsp_fire   = rst_ni && head_valid && (head.timer == '0);
        slot_free  = (32'(pend_cnt) < OUTSTANDING) || rsp_fire;
        accept     = rst_ni && bus.data_req_i && (gnt_cnt_q == 4'(GNT_DELAY)) && slot_free;
        bus_wr     = accept && bus.data_we_i && in_range;

        push_entry.err   = !in_range;
        push_entry.timer = TIMER_W'(RSP_DELAY - 1);
        if (bus.data_we_i) begin
            push_entry.rdata = '0;
        end else if (in_range) begin
            push_entry.rdata = mem_q[idx];
        end else begin
            push_entry.rdata = MEM_ERR_DATA;
        end
    end

    // Wait counter: runs while req is held ungranted, clears on accept or idle.
    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        if (!bus.data_req_i || accept) begin
            gnt_cnt_d = '0;
        end else if (gnt_cnt_q < 4'(GNT_DELAY)) begin
            gnt_cnt_d = gnt_cnt_q + 4'd1;
        end
    end

    // Store-observe capture; fields hold their last value between pulses.
    always_comb begin
        st_valid_d = bus_wr;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        st_be_d    = st_be_q;
        if (bus_wr) begin
            st_addr_d = {bus.data_addr_i[31:2], 2'b00};
            st_data_d = bus.data_wdata_i;
            st_be_d   = bus.data_be_i;
        end
    end

    // Control and store-observe registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_cnt_q  <= '0;
            st_valid_q <= 1'b0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            st_be_q    <= '0;
        end else begin
            gnt_cnt_q  <= gnt_cnt_d;
            st_valid_q <= st_valid_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
            st_be_q    <= st_be_d;
        end
    end

    // SRAM (not reset); the bus write comes last so it overrides the backdoor.
    always_ff @(posedge clk_i) begin
        if (bd_we_i) begin
            mem_q[bd_addr_i] <= bd_wdata_i;
        end
        if (bus_wr) begin
            mem_q[idx] <= be_merge(mem_q[idx], bus.data_wdata_i, bus.data_be_i);
        end
    end

    // A grant must never push into a full queue without a same-cycle retire.
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept) begin
            assert (!q_full || rsp_fire);
        end
    end

    assign bus.data_gnt_o    = accept;
    assign bus.data_rvalid_o = rsp_fire;
    assign bus.data_rdata_o  = rsp_fire ? head.rdata : '0;
    assign bus.data_err_o    = rsp_fire && head.err;

    assign st_valid_o = st_valid_q;
    assign st_addr_o  = st_addr_q;
    assign st_data_o  = st_data_q;
    assign st_be_o    = st_be_q;

endmodule

// File: tb/tb_riscy_data_mem_responder.sv
// Scoreboard bench for riscy_data_mem_responder over three timing configurations:
//   0: GNT_DELAY=0 RSP_DELAY=1   1: GNT_DELAY=0 RSP_DELAY=4   2: GNT_DELAY=3 RSP_DELAY=1
module tb_riscy_data_mem_responder;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_exp_t;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          due;
    } st_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic        req [3];
    logic        we [3];
    logic [3:0]  be [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic        gnt [3];
    logic        rvalid [3];
    logic [31:0] rdata [3];
    logic        err [3];
    logic        bd_we [3];
    logic [9:0]  bd_addr [3];
    logic [31:0] bd_wdata [3];
    logic        st_valid [3];
    logic [31:0] st_addr [3];
    logic [31:0] st_data [3];
    logic [3:0]  st_be [3];

    int rsp_dly [3] = '{1, 4, 1};

    logic [31:0] mdl [3][1024];
    rsp_exp_t    rsp_sb [$];
    st_exp_t     st_sb [$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        last_gnt_rvalid;
    int          mj;

    riscy_data_mem_responder_if bus_a ();
    riscy_data_mem_responder_if bus_b ();
    riscy_data_mem_responder_if bus_c ();

    assign bus_a.data_req_i = req[0];   assign bus_b.data_req_i = req[1];   assign bus_c.data_req_i = req[2];
    assign bus_a.data_we_i = we[0];     assign bus_b.data_we_i = we[1];     assign bus_c.data_we_i = we[2];
    assign bus_a.data_be_i = be[0];     assign bus_b.data_be_i = be[1];     assign bus_c.data_be_i = be[2];
    assign bus_a.data_addr_i = addr[0]; assign bus_b.data_addr_i = addr[1]; assign bus_c.data_addr_i = addr[2];
    assign bus_a.data_wdata_i = wdata[0]; assign bus_b.data_wdata_i = wdata[1]; assign bus_c.data_wdata_i = wdata[2];
    assign gnt[0] = bus_a.data_gnt_o;   assign gnt[1] = bus_b.data_gnt_o;   assign gnt[2] = bus_c.data_gnt_o;
    assign rvalid[0] = bus_a.data_rvalid_o; assign rvalid[1] = bus_b.data_rvalid_o; assign rvalid[2] = bus_c.data_rvalid_o;
    assign rdata[0] = bus_a.data_rdata_o; assign rdata[1] = bus_b.data_rdata_o; assign rdata[2] = bus_c.data_rdata_o;
    assign err[0] = bus_a.data_err_o;   assign err[1] = bus_b.data_err_o;   assign err[2] = bus_c.data_err_o;

    riscy_data_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(0), .RSP_DELAY(1), .OUTSTANDING(2)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a),
        .bd_we_i(bd_we[0]), .bd_addr_i(bd_addr[0]), .bd_wdata_i(bd_wdata[0]),
        .st_valid_o(st_valid[0]), .st_addr_o(st_addr[0]), .st_data_o(st_data[0]), .st_be_o(st_be[0])
    );

    riscy_data_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(0), .RSP_DELAY(4), .OUTSTANDING(2)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b),
        .bd_we_i(bd_we[1]), .bd_addr_i(bd_addr[1]), .bd_wdata_i(bd_wdata[1]),
        .st_valid_o(st_valid[1]), .st_addr_o(st_addr[1]), .st_data_o(st_data[1]), .st_be_o(st_be[1])
    );

    riscy_data_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(3), .RSP_DELAY(1), .OUTSTANDING(2)
    ) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_c),
        .bd_we_i(bd_we[2]), .bd_addr_i(bd_addr[2]), .bd_wdata_i(bd_wdata[2]),
        .st_valid_o(st_valid[2]), .st_addr_o(st_addr[2]), .st_data_o(st_data[2]), .st_be_o(st_be[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lane_write(input logic [31:0] old_w, input logic [31:0] d,
                                               input logic [3:0] b);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old_w & ~mask) | (d & mask);
    endfunction

    task automatic bd_write(input int i, input int unsigned w, input logic [31:0] d);
        bd_we[i] = 1'b1;
        bd_addr[i] = w[9:0];
        bd_wdata[i] = d;
        mdl[i][w] = d;
        @(negedge clk);
        bd_we[i] = 1'b0;
    endtask

    // Drive one request, wait for its grant, and record the expected outcome.
    task automatic issue(input int i, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d, output int waits);
        rsp_exp_t    re;
        st_exp_t     se;
        logic        inr;
        int unsigned wi;
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        waits = 0;
        forever begin
            #1;
            if (gnt[i]) break;
            if (waits >= 40) begin
                check_eq($sformatf("gnt_timeout[%0d]", i), gnt[i], 1'b1);
                req[i] = 1'b0;
                return;
            end
            @(negedge clk);
            waits++;
        end
        last_gnt_rvalid = rvalid[i];
        wi  = a >> 2;
        inr = (wi < 1024);
        re.inst = i;
        re.due  = cyc + rsp_dly[i];
        re.err  = !inr;
        if (w) begin
            re.rdata = 32'h0;
            if (inr) begin
                mdl[i][wi] = lane_write(mdl[i][wi], d, b);
                se.inst = i; se.addr = {a[31:2], 2'b00}; se.data = d; se.be = b; se.due = cyc + 1;
                st_sb.push_back(se);
            end
        end else begin
            re.rdata = inr ? mdl[i][wi] : 32'hDEAD_BEEF;
        end
        rsp_sb.push_back(re);
        @(negedge clk);
    endtask

    task automatic idle(input int i);
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    // Response and store-observe monitor: pop the oldest expectation per instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rvalid[i] === 1'b1) begin
                mj = -1;
                for (int k = 0; k < rsp_sb.size(); k++) begin
                    if (rsp_sb[k].inst == i) begin mj = k; break; end
                end
                if (mj < 0) begin
                    check_eq($sformatf("spurious_rvalid[%0d]", i), rvalid[i], 1'b0);
                end else begin
                    check_eq($sformatf("rdata[%0d]", i), rdata[i], rsp_sb[mj].rdata);
                    check_eq($sformatf("err[%0d]", i), err[i], rsp_sb[mj].err);
                    check_eq($sformatf("rsp_cycle[%0d]", i), cyc, rsp_sb[mj].due);
                    rsp_sb.delete(mj);
                end
            end
            if (st_valid[i] === 1'b1) begin
                mj = -1;
                for (int k = 0; k < st_sb.size(); k++) begin
                    if (st_sb[k].inst == i) begin mj = k; break; end
                end
                if (mj < 0) begin
                    check_eq($sformatf("spurious_st_valid[%0d]", i), st_valid[i], 1'b0);
                end else begin
                    check_eq($sformatf("st_addr[%0d]", i), st_addr[i], st_sb[mj].addr);
                    check_eq($sformatf("st_data[%0d]", i), st_data[i], st_sb[mj].data);
                    check_eq($sformatf("st_be[%0d]", i), st_be[i], st_sb[mj].be);
                    check_eq($sformatf("st_cycle[%0d]", i), cyc, st_sb[mj].due);
                    st_sb.delete(mj);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want finish before 100000");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
            bd_we[i] = 1'b0; bd_addr[i] = 10'h0; bd_wdata[i] = 32'h0;
        end
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_gnt", gnt[0], 1'b0);
        check_eq("rst_rvalid", rvalid[0], 1'b0);
        check_eq("rst_rdata", rdata[0], 32'h0);
        check_eq("rst_err", err[0], 1'b0);
        check_eq("rst_st_valid", st_valid[0], 1'b0);
        check_eq("rst_st_addr", st_addr[0], 32'h0);
        check_eq("rst_st_data", st_data[0], 32'h0);
        check_eq("rst_st_be", st_be[0], 4'h0);
        req[0] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        bd_write(0, 5, 32'h1234_5678);
        bd_write(0, 0, 32'hCAFE_F00D);
        bd_write(1, 5, 32'h1234_5678);
        bd_write(1, 6, 32'h0BAD_F00D);
        for (int unsigned k = 0; k < 4; k++) bd_write(2, k, 32'h5A00_0000 + k);

        // Basic load: grant in the same cycle, data one cycle later.
        issue(0, 1'b0, 4'hF, 32'h14, 32'h0, w);
        check_eq("gnt_lat_load", w, 0);
        idle(0);

        // Partial store then load of the merged word; zero-enable store.
        issue(0, 1'b1, 4'b0011, 32'h14, 32'hAABB_CCDD, w);
        issue(0, 1'b0, 4'hF, 32'h14, 32'h0, w);
        issue(0, 1'b1, 4'b0000, 32'h14, 32'hFFFF_FFFF, w);
        issue(0, 1'b0, 4'hF, 32'h14, 32'h0, w);
        idle(0);

        // Out-of-range load and store; word 0 must not be aliased.
        issue(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, w);
        issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'h5555_5555, w);
        issue(0, 1'b0, 4'hF, 32'h0, 32'h0, w);
        idle(0);

        // Backdoor and bus write to word 7 on the same edge: bus data wins.
        bd_we[0] = 1'b1; bd_addr[0] = 10'd7; bd_wdata[0] = 32'h1111_1111;
        mdl[0][7] = 32'h1111_1111;
        issue(0, 1'b1, 4'hF, 32'h1C, 32'h2222_2222, w);
        bd_we[0] = 1'b0;
        issue(0, 1'b0, 4'hF, 32'h1C, 32'h0, w);
        idle(0);

        // Full-rate stream including store-then-load of the same word.
        issue(0, 1'b0, 4'hF, 32'h14, 32'h0, w);        check_eq("tput0", w, 0);
        issue(0, 1'b1, 4'hF, 32'h20, 32'h0F0F_0F0F, w); check_eq("tput1", w, 0);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0, w);        check_eq("tput2", w, 0);
        issue(0, 1'b0, 4'hF, 32'h0, 32'h0, w);         check_eq("tput3", w, 0);
        idle(0);

        // RSP_DELAY=4, two outstanding: the third waits for the first retire
        // (accepts at edges k, k+1; first rvalid two cycles after the third req).
        issue(1, 1'b0, 4'hF, 32'h14, 32'h0, w); check_eq("out_gnt1", w, 0);
        issue(1, 1'b0, 4'hF, 32'h18, 32'h0, w); check_eq("out_gnt2", w, 0);
        issue(1, 1'b0, 4'hF, 32'h14, 32'h0, w); check_eq("out_gnt3_wait", w, 2);
        check_eq("out_gnt3_with_rvalid", last_gnt_rvalid, 1'b1);
        idle(1);
        repeat (8) @(negedge clk);

        // Reset with two responses in flight: nothing may come out afterwards.
        issue(1, 1'b0, 4'hF, 32'h14, 32'h0, w);
        issue(1, 1'b0, 4'hF, 32'h18, 32'h0, w);
        rst_n = 1'b0;
        for (int k = rsp_sb.size() - 1; k >= 0; k--) begin
            if (rsp_sb[k].inst == 1) rsp_sb.delete(k);
        end
        #1;
        check_eq("rst_gnt_b", gnt[1], 1'b0);
        @(negedge clk);
        req[1] = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(1, 1'b0, 4'hF, 32'h14, 32'h0, w);
        idle(1);

        // GNT_DELAY=3 back-to-back loads.
        for (int unsigned k = 0; k < 4; k++) begin
            issue(2, 1'b0, 4'hF, k * 4, 32'h0, w);
            check_eq($sformatf("gnt_dly3_%0d", k), w, 3);
        end
        idle(2);

        repeat (10) @(negedge clk);
        check_eq("rsp_sb_empty", rsp_sb.size(), 0);
        check_eq("st_sb_empty", st_sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
